straight_check_scan: RTL and testbench
======================================

# straight_check_scan

Sequential rook/queen threat detector for the chess-rules datapath. On `start` it latches the packed 64-square board and a king square. It walks the four orthogonal rays outward from the king, one square per clock, and reports whether an enemy rook or queen attacks the king along a rank or file. It sits directly downstream of the packed-board register and feeds the move-legality / check-status logic. Its ray walk and nearest-piece encoding match the existing orthogonal scanner.

## Interface
- No parameters.
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: synchronous, active-high; returns the block to IDLE and clears all outputs.
- `start` input 1: request a scan; sampled only in IDLE.
- `bigBoard` input 256: square s occupies bits [4s+3:4s]; [2:0] is the piece type, [3] is the colour (1 = black).
- `kingPosition` input 6: king square; [2:0] is the row within the column, [5:3] is the column.
- `kingColor` input 1: colour of the king being tested.
- `busy` output 1: high from LOAD through the last STEP cycle.
- `done` output 1: one-cycle pulse; results are valid from this cycle on.
- `inCheck` output 1: an enemy rook or queen attacks the king.
- `attackerPosition` output 6: square of the first attacker found.
- `attackerPiece` output 4: full nibble of that attacker.
- `attackDirection` output 2: ray of the attacker; UP=0, LEFT=1, RIGHT=2, DOWN=3.
- `attackerCount` output 3: present only with STRAIGHT_CHECK_COUNT_EN.

## Operation
- Piece codes: 0 empty, 1 pawn, 2 knight, 3 bishop, 4 rook, 5 queen, 6 king, 7 reserved (treated as a blocker).
- Ray deltas: UP −1 (stop at row 0), DOWN +1 (stop at row 7), LEFT −8 (stop at column 0), RIGHT +8 (stop at column 7).
- The walk never wraps across a column or the board edge.
- Directions are scanned in the fixed order UP, LEFT, RIGHT, DOWN.
- FSM states: IDLE, LOAD, STEP, DONE.
- IDLE:
  - `start`=1 latches `bigBoard`, `kingPosition` and `kingColor`, then moves to LOAD.
  - Input changes after the latch are ignored.
- LOAD: clears the result registers, selects UP, sets cursor = king square, then moves to STEP.
- STEP: each cycle handles exactly one of three cases.
  - Ray exhausted (cursor at the edge for this direction): advance direction; after DOWN, go to DONE.
  - Examined square empty: advance the cursor and stay on this ray.
  - Examined square occupied:
    - If colour ≠ `kingColor` and type ∈ {4,5}: it is an attacker. Set `inCheck` and record position, nibble and direction (first attacker only). Then go to DONE.
    - Otherwise it is a blocker: advance direction, or go to DONE after DOWN.
- A ray with zero squares (king on that edge) costs exactly one STEP cycle.
- DONE: `done`=1 for one cycle, then IDLE. Results hold until the next LOAD.
- `start` while busy or in DONE is ignored. It is not queued.
- Reset mid-scan aborts at the next edge. No `done` pulse is issued.

## Timing
- Reset values: `busy`, `done`, `inCheck`, `attackerPosition`, `attackerPiece`, `attackDirection` and `attackerCount` are all 0. The state is IDLE.
- Start sampled at edge E0:
  - LOAD occupies cycle 1.
  - STEP cycles run from 2 to 1+N, where N = sum over scanned rays of max(1, squares examined).
  - `done` is high in cycle 2+N.
- Worst case is N = 16: king in a corner, empty board. `done` is then in cycle 18.
- Earliest `done` is cycle 3. Example: king at row 1 with an enemy rook directly above it; UP finds the attacker in the first STEP cycle.
- `busy` is low in the `done` cycle. A new `start` is accepted one cycle after `done`.

## Configuration
- `STRAIGHT_CHECK_COUNT_EN` defined:
  - All four rays are always scanned; there is no early exit.
  - `attackerCount` holds the number of attacking rays, 0–4, saturating at 3 bits.
  - The `attacker*` outputs still report the first attacker in scan order.
  - N always includes all four rays.
- Undefined: the block exits on the first attacker, and the `attackerCount` port is absent.

## Structure
- Shared package `chess_pkg` holds:
  - piece-type constants (EMPTY, PAWN, KNIGHT, BISHOP, ROOK, QUEEN, KING);
  - colour constants (WHITE=0, BLACK=1);
  - direction constants (UP, LEFT, RIGHT, DOWN);
  - FSM state encodings.
- One sub-module, `ray_cursor`:
  - Inputs: the current square and direction.
  - Outputs: the next square and an `atEdge` flag.
  - Purely combinational, and it carries the no-wrap rules.
- The top level holds the FSM, the latched board and the result registers.

## Test plan
- Empty board, king white at square 0, start → `done` in cycle 18, `inCheck`=0, `busy` high cycles 1–17.
- Black rook (nibble 4'b1100) at square 5, white king at 0 → `inCheck`=1, `attackerPosition`=5, `attackDirection`=DOWN, `attackerPiece`=4'hC.
- White king at 27, white pawn at 35, black queen at 43 → RIGHT ray blocked, `inCheck`=0.
- White king at 7 (row 7, column 0), black rook at 15 (row 7, column 1) → `inCheck`=1 with `attackDirection`=RIGHT. Confirms no wrap of DOWN into column 1.
- Reset asserted in cycle 5 of a scan → next cycle all outputs 0, no `done`. A fresh start then scans normally.
- With STRAIGHT_CHECK_COUNT_EN: white king at 27, black rooks at 24 and 59 → `attackerCount`=2, `attackerPosition`=24 (UP found first).

Source files
------------

// File: rtl/chess_pkg.sv
// Shared chess datapath constants: piece codes, colours, ray directions, scanner FSM states.
package chess_pkg;

  localparam logic [2:0] EMPTY  = 3'd0;
  localparam logic [2:0] PAWN   = 3'd1;
  localparam logic [2:0] KNIGHT = 3'd2;
  localparam logic [2:0] BISHOP = 3'd3;
  localparam logic [2:0] ROOK   = 3'd4;
  localparam logic [2:0] QUEEN  = 3'd5;
  localparam logic [2:0] KING   = 3'd6;

  localparam logic WHITE = 1'b0;
  localparam logic BLACK = 1'b1;

  typedef enum logic [1:0] {UP = 2'd0, LEFT = 2'd1, RIGHT = 2'd2, DOWN = 2'd3} dir_t;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_STEP = 2'd2, S_DONE = 2'd3} state_t;

  // Enemy rook or queen relative to the king colour; code 7 and others are blockers.
  function automatic logic is_straight_attacker(input logic [3:0] nib, input logic king_color);
    return (nib[2:0] == ROOK || nib[2:0] == QUEEN) && (nib[3] != king_color);
  endfunction

endpackage

// File: rtl/ray_cursor.sv
// One orthogonal ray step: neighbouring square in a direction plus an edge flag.
// Rows live in square[2:0], columns in square[5:3]; a step never wraps.
module ray_cursor
  import chess_pkg::*;
(
  input  logic [5:0] square,
  input  logic [1:0] dir,
  output logic [5:0] next,
  output logic       atEdge
);

  always_comb begin
    next   = square;
    atEdge = 1'b0;
    case (dir)
      UP: begin
        atEdge = (square[2:0] == 3'd0);
        next   = square - 6'd1;
      end
      DOWN: begin
        atEdge = (square[2:0] == 3'd7);
        next   = square + 6'd1;
      end
      LEFT: begin
        atEdge = (square[5:3] == 3'd0);
        next   = square - 6'd8;
      end
      default: begin
        atEdge = (square[5:3] == 3'd7);
        next   = square + 6'd8;
      end
    endcase
  end

endmodule

// File: rtl/straight_check_scan.sv
// Sequential rook/queen check detector walking UP, LEFT, RIGHT, DOWN from the king.
// Optional STRAIGHT_CHECK_COUNT_EN: scan all rays and count attacking rays.
module straight_check_scan
  import chess_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [255:0] bigBoard,
  input  logic [5:0]   kingPosition,
  input  logic         kingColor,
  output logic         busy,
  output logic         done,
  output logic         inCheck,
  output logic [5:0]   attackerPosition,
  output logic [3:0]   attackerPiece,
  output logic [1:0]   attackDirection
`ifdef STRAIGHT_CHECK_COUNT_EN
  ,
  output logic [2:0]   attackerCount
`endif
);

  state_t         state, state_nx;
  logic [255:0]   board_q;
  logic [5:0]     king_q;
  logic           kcol_q;
  logic [5:0]     cur_q;
  dir_t           dir_q;
  logic           chk_q;
  logic [5:0]     pos_q;
  logic [3:0]     pc_q;
  logic [1:0]     adir_q;
  logic [2:0]     cnt_q;

  logic [5:0]     nxt;
  logic           cur_edge;
  logic [5:0]     look_next_unused;
  logic           nxt_edge;
  logic [3:0]     nib;
  logic           occ, att, ray_end, finish;

  ray_cursor u_cur (.square(cur_q), .dir(dir_q), .next(nxt),              .atEdge(cur_edge));
  // Look one square further so an empty ray ends on its last square, not one cycle later.
  ray_cursor u_look(.square(nxt),   .dir(dir_q), .next(look_next_unused), .atEdge(nxt_edge));

  always_comb begin
    nib     = board_q[{nxt, 2'b00} +: 4];
    occ     = (nib[2:0] != EMPTY);
    att     = !cur_edge && occ && is_straight_attacker(nib, kcol_q);
`ifdef STRAIGHT_CHECK_COUNT_EN
    ray_end = cur_edge || occ || nxt_edge;
    finish  = ray_end && (dir_q == DOWN);
`else
    ray_end = cur_edge || (occ && !att) || (!occ && nxt_edge);
    finish  = (ray_end && (dir_q == DOWN)) || att;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_LOAD;
      S_LOAD:  state_nx = S_STEP;
      S_STEP:  if (finish) state_nx = S_DONE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_LOAD) || (state == S_STEP);
    done = (state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      board_q <= '0;
      king_q  <= '0;
      kcol_q  <= 1'b0;
      cur_q   <= '0;
      dir_q   <= UP;
      chk_q   <= 1'b0;
      pos_q   <= '0;
      pc_q    <= '0;
      adir_q  <= '0;
      cnt_q   <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          board_q <= bigBoard;
          king_q  <= kingPosition;
          kcol_q  <= kingColor;
        end
        S_LOAD: begin
          chk_q  <= 1'b0;
          pos_q  <= '0;
          pc_q   <= '0;
          adir_q <= '0;
          cnt_q  <= '0;
          dir_q  <= UP;
          cur_q  <= king_q;
        end
        S_STEP: begin
          if (att) begin
            if (!chk_q) begin
              chk_q  <= 1'b1;
              pos_q  <= nxt;
              pc_q   <= nib;
              adir_q <= dir_q;
            end
            if (cnt_q != 3'd7) cnt_q <= cnt_q + 3'd1;
          end
          if (ray_end) begin
            dir_q <= dir_t'(dir_q + 2'd1);
            cur_q <= king_q;
          end else begin
            cur_q <= nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign inCheck          = chk_q;
  assign attackerPosition = pos_q;
  assign attackerPiece    = pc_q;
  assign attackDirection  = adir_q;
`ifdef STRAIGHT_CHECK_COUNT_EN
  assign attackerCount    = cnt_q;
`endif

endmodule

// File: tb/tb_straight_check_scan.sv
// Scoreboard bench for straight_check_scan: a row/column ray-walk model predicts
// each scan's result, latency and busy length; a monitor checks on every done pulse.
module tb_straight_check_scan;
  import chess_pkg::*;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [255:0] bigBoard = '0;
  logic [5:0]   kingPosition = '0;
  logic         kingColor = 1'b0;
  logic         busy, done, inCheck;
  logic [5:0]   attackerPosition;
  logic [3:0]   attackerPiece;
  logic [1:0]   attackDirection;
`ifdef STRAIGHT_CHECK_COUNT_EN
  logic [2:0]   attackerCount;
`endif

  straight_check_scan dut (
    .clk(clk), .reset(reset), .start(start), .bigBoard(bigBoard),
    .kingPosition(kingPosition), .kingColor(kingColor),
    .busy(busy), .done(done), .inCheck(inCheck),
    .attackerPosition(attackerPosition), .attackerPiece(attackerPiece),
    .attackDirection(attackDirection)
`ifdef STRAIGHT_CHECK_COUNT_EN
    , .attackerCount(attackerCount)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       chk;
    logic [5:0] pos;
    logic [3:0] pc;
    logic [1:0] dir;
    logic [2:0] cnt;
    int         n;
    int         e0;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;
  int busy_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  // Walk each ray by row/column arithmetic; count squares looked at until a piece or the edge.
  function automatic exp_t model(input logic [255:0] b, input int k, input logic kc);
    exp_t e;
    int dr[4];
    int dc[4];
    dr = '{-1, 0, 0, 1};
    dc = '{0, -1, 1, 0};
    e.chk = 1'b0; e.pos = '0; e.pc = '0; e.dir = '0; e.cnt = '0; e.n = 0; e.e0 = 0;
    for (int d = 0; d < 4; d++) begin
      int r, c, seen;
      logic [3:0] p;
      bit stop;
      r = k % 8; c = k / 8; seen = 0; stop = 0;
      while (!stop) begin
        r += dr[d];
        c += dc[d];
        if (r < 0 || r > 7 || c < 0 || c > 7) break;
        seen++;
        p = b[(c * 8 + r) * 4 +: 4];
        if (p[2:0] != 3'd0) begin
          stop = 1;
          if (p[3] != kc && (p[2:0] == 3'd4 || p[2:0] == 3'd5)) begin
            if (!e.chk) begin
              e.chk = 1'b1;
              e.pos = 6'(c * 8 + r);
              e.pc  = p;
              e.dir = 2'(d);
            end
            if (e.cnt != 3'd7) e.cnt++;
          end
        end
      end
      e.n += (seen == 0) ? 1 : seen;
`ifndef STRAIGHT_CHECK_COUNT_EN
      if (e.chk) break;
`endif
    end
    return e;
  endfunction

  always @(negedge clk) begin : mon
    exp_t e;
    if (reset) busy_cnt = 0;
    else begin
      if (busy) busy_cnt++;
      if (done) begin
        if (sb.size() == 0) chk("spurious_done", 1, 0);
        else begin
          e = sb.pop_front();
          chk("inCheck", inCheck, e.chk);
          chk("attackerPosition", attackerPosition, e.pos);
          chk("attackerPiece", attackerPiece, e.pc);
          chk("attackDirection", attackDirection, e.dir);
`ifdef STRAIGHT_CHECK_COUNT_EN
          chk("attackerCount", attackerCount, e.cnt);
`endif
          chk("done_latency", cyc, e.e0 + 1 + e.n);
          chk("busy_cycles", busy_cnt, 1 + e.n);
          chk("busy_in_done", busy, 0);
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic run_scan(input logic [255:0] b, input logic [5:0] k, input logic kc, input bit scramble);
    exp_t e;
    int t;
    logic [255:0] junk;
    @(negedge clk);
    bigBoard = b; kingPosition = k; kingColor = kc; start = 1'b1;
    @(posedge clk);
    #1;
    e = model(b, k, kc);
    e.e0 = cyc;
    sb.push_back(e);
    if (scramble) begin
      for (int i = 0; i < 8; i++) junk[i * 32 +: 32] = $urandom;
      bigBoard = junk; kingPosition = 6'($urandom); kingColor = ~kc;
    end else start = 1'b0;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!done && t < 40);
    start = 1'b0;
    if (!done) begin
      chk("done_timeout", 0, 1);
      sb.delete();
    end
    @(negedge clk);
    chk("hold_inCheck", inCheck, e.chk);
    chk("hold_attackerPosition", attackerPosition, e.pos);
  endtask

  function automatic logic [255:0] put(input logic [255:0] b, input int s, input logic [3:0] nib);
    logic [255:0] r;
    r = b;
    r[s * 4 +: 4] = nib;
    return r;
  endfunction

  initial begin
    logic [255:0] b;
    logic [5:0] k;
    logic kc;
    int t;

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_inCheck", inCheck, 0);
    chk("rst_attackerPosition", attackerPosition, 0);
    chk("rst_attackerPiece", attackerPiece, 0);
    chk("rst_attackDirection", attackDirection, 0);
`ifdef STRAIGHT_CHECK_COUNT_EN
    chk("rst_attackerCount", attackerCount, 0);
`endif
    reset = 1'b0;

    run_scan('0, 6'd0, WHITE, 0);
    run_scan(put('0, 5, 4'hC), 6'd0, WHITE, 0);
    b = put(put(put('0, 27, 4'h6), 35, 4'h1), 43, 4'hD);
    run_scan(b, 6'd27, WHITE, 0);
    run_scan(put(put('0, 7, 4'h6), 15, 4'hC), 6'd7, WHITE, 1);
    run_scan(put(put('0, 26, 4'hC), 27, 4'h6), 6'd27, WHITE, 0);
    run_scan(put(put(put('0, 27, 4'h6), 24, 4'hC), 59, 4'hC), 6'd27, WHITE, 0);
    run_scan(put('0, 40, 4'h5), 6'd0, BLACK, 0);

    // Abort a long scan with reset during cycle 5; it must leave no done behind.
    @(negedge clk);
    bigBoard = put('0, 56, 4'hC); kingPosition = 6'd0; kingColor = WHITE; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    chk("busy_before_abort", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_inCheck", inCheck, 0);
    chk("abort_attackerPosition", attackerPosition, 0);
    chk("abort_attackerPiece", attackerPiece, 0);
    chk("abort_attackDirection", attackDirection, 0);
    reset = 1'b0;
    repeat (25) @(negedge clk);
    run_scan(put('0, 56, 4'hC), 6'd0, WHITE, 0);

    for (int n = 0; n < 60; n++) begin
      b = '0;
      for (int s = 0; s < 64; s++) begin
        if ($urandom_range(0, 99) < 25) begin
          if ($urandom_range(0, 1) == 1) b[s * 4 +: 4] = 4'($urandom_range(0, 15));
          else b[s * 4 +: 4] = {1'($urandom_range(0, 1)), 3'($urandom_range(4, 5))};
        end
      end
      k = 6'($urandom_range(0, 63));
      kc = 1'($urandom_range(0, 1));
      b[k * 4 +: 4] = {kc, KING};
      run_scan(b, k, kc, bit'($urandom_range(0, 1)));
    end

    t = 0;
    while (sb.size() != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("scoreboard_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
